// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The requester side drives Req; the arbiter drives the grant signals.
interface rr_decoder_arbiter_if;
    logic [3:0] Req;
    logic [3:0] Gnt;
    logic [1:0] GntIdx;
    logic       GntValid;
    logic       Preempt;

    modport master (
        output Req,
        input  Gnt,
        input  GntIdx,
        input  GntValid,
        input  Preempt
    );

    modport slave (
        input  Req,
        output Gnt,
        output GntIdx,
        output GntValid,
        output Preempt
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with a hold timer. The winner is kept as a
// 2-bit index and decoded to a registered one-hot grant.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic             Clk,
    input logic             Rst,
    rr_decoder_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    function automatic logic [3:0] decode_idx(input logic [1:0] idx, input logic valid);
        logic [3:0] onehot_v;
        case (idx)
            2'b00:   onehot_v = 4'b0001;
            2'b01:   onehot_v = 4'b0010;
            2'b10:   onehot_v = 4'b0100;
            2'b11:   onehot_v = 4'b1000;
            default: onehot_v = 4'b0000;
        endcase
        return valid ? onehot_v : 4'b0000;
    endfunction

    // Returns {found, index}: first asserted request at or after ptr, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found_v;
        logic [1:0] idx_v;
        logic [1:0] cand_v;
        found_v = 1'b0;
        idx_v   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cand_v  = ptr + 2'(i);
            idx_v   = (!found_v && req[cand_v]) ? cand_v : idx_v;
            found_v = found_v | req[cand_v];
        end
        return {found_v, idx_v};
    endfunction

    logic [0:0] state_r;
    logic [1:0] ptr_r;
    logic [1:0] gnt_idx_r;
    logic       gnt_valid_r;
    logic [3:0] gnt_r;
    logic       preempt_r;
    logic [7:0] hold_cnt_r;

    logic [0:0] state_s;
    logic [1:0] ptr_s;
    logic [1:0] gnt_idx_s;
    logic       gnt_valid_s;
    logic       preempt_s;
    logic [7:0] hold_cnt_s;
    logic [2:0] pick_s;
    logic       others_s;

    assign pick_s   = rr_pick(bus.Req, ptr_r);
    assign others_s = |(bus.Req & ~decode_idx(gnt_idx_r, 1'b1));

    // Next-state decision: pick a winner in IDLE, release or pre-empt in GRANT.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        gnt_idx_s   = gnt_idx_r;
        gnt_valid_s = gnt_valid_r;
        hold_cnt_s  = hold_cnt_r;
        preempt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_s     = GRANT;
                    gnt_idx_s   = pick_s[1:0];
                    gnt_valid_s = 1'b1;
                    hold_cnt_s  = 8'd0;
                end else begin
                    gnt_idx_s   = 2'b00;
                    gnt_valid_s = 1'b0;
                end
            end
            GRANT: begin
                // Release is tested first so a timeout coinciding with a drop is not a pre-emption.
                if (!bus.Req[gnt_idx_r]) begin
                    state_s     = IDLE;
                    gnt_idx_s   = 2'b00;
                    gnt_valid_s = 1'b0;
                    ptr_s       = gnt_idx_r + 2'd1;
                    hold_cnt_s  = 8'd0;
                end else if ((hold_cnt_r == HOLD_LAST) && others_s) begin
                    state_s     = IDLE;
                    gnt_idx_s   = 2'b00;
                    gnt_valid_s = 1'b0;
                    ptr_s       = gnt_idx_r + 2'd1;
                    hold_cnt_s  = 8'd0;
                    preempt_s   = 1'b1;
                end else begin
                    hold_cnt_s  = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                gnt_idx_s   = 2'b00;
                gnt_valid_s = 1'b0;
                hold_cnt_s  = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'b00;
            gnt_idx_r   <= 2'b00;
            gnt_valid_r <= 1'b0;
            gnt_r       <= 4'b0000;
            preempt_r   <= 1'b0;
            hold_cnt_r  <= 8'd0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            gnt_idx_r   <= gnt_idx_s;
            gnt_valid_r <= gnt_valid_s;
            gnt_r       <= decode_idx(gnt_idx_s, gnt_valid_s);
            preempt_r   <= preempt_s;
            hold_cnt_r  <= hold_cnt_s;
        end
    end

    assign bus.Gnt      = gnt_r;
    assign bus.GntIdx   = gnt_idx_r;
    assign bus.GntValid = gnt_valid_r;
    assign bus.Preempt  = preempt_r;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: directed vector table,
// hand-written multi-cycle sequences and randomized requests vs a reference model.
module tb_rr_decoder_arbiter;

    localparam int MH = 4;

    logic Clk;
    logic Rst;
    rr_decoder_arbiter_if bus_i ();

    rr_decoder_arbiter #(.MAX_HOLD(MH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_i.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_pre   = 1'b0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] exp;   // {Gnt, GntIdx, GntValid, Preempt}
    } vec_t;

    vec_t vecs[20];

    task automatic model_step(input logic rst, input logic [3:0] req);
        logic [3:0] others;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 1'b0;
        end else if (m_owner < 0) begin
            m_pre = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0 && req[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
            end
            m_hold = 0;
        end else begin
            m_pre = 1'b0;
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1;
            end else if (m_hold == MH - 1 && others != 4'b0000) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1; m_pre = 1'b1;
            end else if (m_hold < MH - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic logic [7:0] model_exp();
        logic [3:0] g;
        logic [1:0] idx;
        g   = 4'b0000;
        idx = 2'b00;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            idx = 2'(m_owner);
        end
        return {g, idx, (m_owner >= 0), m_pre};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus_i.Gnt, bus_i.GntIdx, bus_i.GntValid, bus_i.Preempt};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {gnt,idx,valid,pre}=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req);
        Rst = rst;
        bus_i.Req = req;
        @(posedge Clk);
        model_step(rst, req);
        #1;
    endtask

    logic [3:0] req_v;
    logic [3:0] prev_gnt;
    logic [3:0] order_q[$];

    initial begin
        Rst = 1'b1;
        bus_i.Req = 4'b0000;

        // Reset, single request, pre-emption, release at timeout (MAX_HOLD = 4).
        vecs[0]  = '{1'b1, 4'b0000, 8'b0000_00_0_0};
        vecs[1]  = '{1'b1, 4'b0100, 8'b0000_00_0_0};
        vecs[2]  = '{1'b0, 4'b0100, 8'b0100_10_1_0};
        vecs[3]  = '{1'b0, 4'b0100, 8'b0100_10_1_0};
        vecs[4]  = '{1'b0, 4'b0000, 8'b0000_00_0_0};
        vecs[5]  = '{1'b0, 4'b0000, 8'b0000_00_0_0};
        vecs[6]  = '{1'b0, 4'b0001, 8'b0001_00_1_0};
        vecs[7]  = '{1'b0, 4'b0001, 8'b0001_00_1_0};
        vecs[8]  = '{1'b0, 4'b0101, 8'b0001_00_1_0};
        vecs[9]  = '{1'b0, 4'b0101, 8'b0001_00_1_0};
        vecs[10] = '{1'b0, 4'b0101, 8'b0000_00_0_1};
        vecs[11] = '{1'b0, 4'b0101, 8'b0100_10_1_0};
        vecs[12] = '{1'b0, 4'b0000, 8'b0000_00_0_0};
        vecs[13] = '{1'b0, 4'b0011, 8'b0001_00_1_0};
        vecs[14] = '{1'b0, 4'b0011, 8'b0001_00_1_0};
        vecs[15] = '{1'b0, 4'b0011, 8'b0001_00_1_0};
        vecs[16] = '{1'b0, 4'b0011, 8'b0001_00_1_0};
        vecs[17] = '{1'b0, 4'b0010, 8'b0000_00_0_0};
        vecs[18] = '{1'b0, 4'b0010, 8'b0010_01_1_0};
        vecs[19] = '{1'b0, 4'b0000, 8'b0000_00_0_0};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Round-robin rotation: all request, each grantee drops after two cycles.
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        prev_gnt = 4'b0000;
        for (int c = 0; c < 40; c++) begin
            req_v = 4'b1111;
            if (m_owner >= 0 && m_hold == 1) req_v[m_owner] = 1'b0;
            step(1'b0, req_v);
            check("rotation_model", dut_out(), model_exp());
            if (bus_i.Gnt != 4'b0000 && prev_gnt == 4'b0000) order_q.push_back(bus_i.Gnt);
            prev_gnt = bus_i.Gnt;
        end
        n_tests++;
        if (order_q.size() < 5) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants, expected at least 5", order_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                req_v = 4'b0000;
                req_v[i % 4] = 1'b1;
                check($sformatf("rotation_order%0d", i), {order_q[i], 4'b0000}, {req_v, 4'b0000});
            end
        end

        // No contention: a lone requester keeps the grant with no pre-emption.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        for (int c = 0; c < 20; c++) begin
            check("lone_hold", dut_out(), 8'b0010_01_1_0);
            step(1'b0, 4'b0010);
        end

        // Reset mid-grant: pointer returns to 0, so 0001 wins over 1000 afterwards.
        step(1'b0, 4'b0000);
        check("lone_release", dut_out(), 8'b0000_00_0_0);
        step(1'b0, 4'b1000);
        check("mid_grant3", dut_out(), 8'b1000_11_1_0);
        step(1'b0, 4'b1000);
        step(1'b1, 4'b1001);
        check("mid_reset", dut_out(), 8'b0000_00_0_0);
        step(1'b0, 4'b1001);
        check("post_reset_grant", dut_out(), 8'b0001_00_1_0);

        // Randomized requests with sticky bits and occasional reset.
        req_v = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3, 0) == 0) req_v[b] = ~req_v[b];
            end
            step(($urandom_range(59, 0) == 0), req_v);
            check("random_model", dut_out(), model_exp());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
